// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and SRAM slave state type
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } sram_fsm_e;

endpackage

// File: rtl/ahb_byte_lane_ram.sv
// rtl/ahb_byte_lane_ram.sv - word-wide RAM with per-byte write enables and one registered read port
module ahb_byte_lane_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 1024,
    parameter int AW         = $clog2(WORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && wbe[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read data holds between reads so the slave output stays stable outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
// Optional: AHB_SRAM_RANGE_ERR_EN makes addresses beyond MEM_BYTES answer ERROR instead of aliasing.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int         LANES  = DATA_WIDTH / 8;
    localparam int         LB     = $clog2(LANES);
    localparam int         MEM_AW = $clog2(MEM_BYTES);
    localparam int         WAW    = MEM_AW - LB;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    sram_fsm_e             state;
    logic [3:0]            wait_cnt;
    logic [MEM_AW-1:0]     addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  ready_q;
    logic                  resp_q;
    logic [LANES-1:0]      fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  accept, bad_size, misaligned, range_err, req_err;
    logic                  done_write, rd_en;
    logic [WAW-1:0]        rd_word, wr_word;
    logic [LANES-1:0]      wr_be;
    logic                  unused_ok;

    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] off);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(off) && i < int'(off) + int'(32'd1 << size)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign bad_size   = HSIZE > 3'(LB);
    assign misaligned = (HADDR[LB-1:0] & LB'((32'd1 << HSIZE) - 32'd1)) != '0;
`ifdef AHB_SRAM_RANGE_ERR_EN
    assign range_err  = (HADDR >> MEM_AW) != '0;
`else
    assign range_err  = 1'b0;
`endif
    assign req_err    = bad_size | misaligned | range_err;
    assign unused_ok  = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, HADDR};

    assign done_write = (state == ST_DONE) && write_q;
    assign wr_word    = addr_q[MEM_AW-1:LB];
    assign wr_be      = lane_mask(size_q, addr_q[LB-1:0]);

    // Zero-wait reads sample the RAM at acceptance; waited reads sample it on the last WAIT edge.
    assign rd_en   = (accept && !req_err && !HWRITE && WAIT_STATES == 0)
                   || (state == ST_WAIT && wait_cnt == 4'd0 && !write_q);
    assign rd_word = (state == ST_WAIT) ? addr_q[MEM_AW-1:LB] : HADDR[MEM_AW-1:LB];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            ready_q  <= 1'b1;
            resp_q   <= HRESP_OKAY;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_DONE;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        addr_q  <= HADDR[MEM_AW-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (req_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS - 4'd1;
                            ready_q  <= 1'b0;
                            resp_q   <= HRESP_OKAY;
                        end else begin
                            state   <= ST_DONE;
                            ready_q <= 1'b1;
                            resp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // A read landing on the word being written this edge takes the new bytes from HWDATA.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_be   <= '0;
            fwd_data <= '0;
        end else if (rd_en) begin
            fwd_be   <= (done_write && rd_word == wr_word) ? wr_be : '0;
            fwd_data <= HWDATA;
        end
    end

    always_comb begin
        HRDATA = ram_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (fwd_be[i]) HRDATA[i*8 +: 8] = fwd_data[i*8 +: 8];
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

    ahb_byte_lane_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (MEM_BYTES / LANES),
        .AW         (WAW)
    ) u_ram (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (done_write),
        .wbe   (wr_be),
        .waddr (wr_word),
        .wdata (HWDATA),
        .re    (rd_en),
        .raddr (rd_word),
        .rdata (ram_rdata)
    );

endmodule
